fir_shift_approx_pipe: RTL and testbench
========================================

Name: fir_shift_approx_pipe

Overview:
Parametrised multiplierless FIR. Coefficients are right-shift amounts, so y[n] = sum over i of (x[n-i] >> SHIFT_i).
Generalises the fixed 5-tap, 16-bit shift filter with the following:
- configurable width, tap count and shift set
- sample-valid handshake
- runtime exact/approximate adder mode
- a primed (delay-line-full) indication
- a registered, fixed-latency output

Sits between the sample source and the downstream datapath in the approximate-arithmetic FIR evaluation chain.

Parameters:
DATA_W, 16, sample and result width (unsigned).
TAPS, 5, number of taps, 2..16.
SHIFTS, {4'd1,4'd2,4'd3,4'd4,4'd5}, packed 4 bits per tap; tap i uses SHIFTS[4*i+:4]. Tap 0 is the newest sample, so the default gives tap0 >> 5 ... tap4 >> 1.
APPROX_K, 2, approximation depth: the carry out of bit APPROX_K-1 is taken as a[K-1] & b[K-1] only (propagate path cut). 0 = exact.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of the delay line, fill counter and pipeline valids
in_valid  in  1  sample strobe
in_data  in  DATA_W  input sample x[n]
approx_en  in  1  1 = approximate adders, 0 = exact; sampled together with in_valid
out_valid  out  1  result strobe
out_data  out  DATA_W  y[n], modulo 2^DATA_W
out_primed  out  1  high when out_data covers TAPS real samples

Behaviour:
- Reset (async, rst=1): clears delay line, fill counter and all pipeline registers. out_valid=0, out_data=0, out_primed=0.
- Delay line (TAPS-1 registers):
  - Shifts only on in_valid=1; holds otherwise, so gaps do not disturb history.
  - Tap 0 is in_data combinationally; taps 1..TAPS-1 are the registered history.
- Terms: t_i = tap_i >> SHIFT_i (logical; zero-filled).
- Summation:
  - Left-to-right chain: s = ((t0+t1)+t2)+... using TAPS-1 instances of the adder sub-module.
  - Each adder is DATA_W bits; carry-out discarded (wrap); carry-in tied to 0.
  - approx_en=1: each adder applies the APPROX_K carry cut. Bits below K are added exactly among themselves.
  - approx_en=0: exact sum.
- Latency (base build): 1 cycle. When in_valid=1 at edge n, then at edge n+1: out_valid=1 and out_data=s. In all other cycles out_valid=0 and out_data holds its last value.
- Fill counter:
  - Saturating count of accepted samples, range 0..TAPS.
  - out_primed is registered alongside out_data. It is 1 when the sample producing this output brings the count to TAPS.
  - Stays 1 until rst or flush.
- flush:
  - Has priority over a simultaneous in_valid; that sample is dropped.
  - Next cycle: history=0, count=0, out_valid=0. out_data holds.
- approx_en change: takes effect on the next accepted sample only; no glitching of held outputs.

Optional Feature:
FIR_PIPE_EN.
- Defined:
  - Stage 1 registers all TAPS terms plus approx_en and a valid bit.
  - Stage 2 registers the adder-chain sum.
  - Latency = 2 cycles; out_primed is delayed to match.
  - flush also clears the stage-1 valid bit, so an in-flight result is suppressed.
- Undefined: single-stage, latency 1, as above.
- In both cases the port list is identical and back-to-back in_valid gives one result per cycle.

Decomposition:
- Package fir_pkg:
  - SHIFT_W=4 constant.
  - Tap-count limit constant (16).
  - Function extracting SHIFT_i from SHIFTS.
  - Typedef for the term array, logic [DATA_W-1:0] per tap.
- Sub-module approx_adder:
  - Parameters DATA_W and APPROX_K; ports a, b, approx_en, sum.
  - Purely combinational, one instance per chain link.
  - Verified standalone against a + b and against the carry-cut reference model.

Test Plan:
1. Impulse, exact mode: 0x0400, then four 0x0000, in_valid each cycle -> out_data 32, 64, 128, 256, 512. out_primed=1 only on the 5th output.
2. Step, exact mode: constant 0xFFFF for 5 samples -> 5th output 0xF7FB (63483), out_primed=1.
3. Carry cut: 0x0010 then 0x0060 -> second output 4 with approx_en=0, and 0 with approx_en=1. Confirms the bit-1 propagate path is cut at K=2.
4. Gapped valid: impulse 0x0400 with in_valid low for 3 cycles between samples -> same sequence as scenario 1. out_valid pulses only after accepted samples; out_data holds between pulses.
5. Flush with simultaneous in_valid mid-stream (after 3 samples of 0xFFFF) -> that sample is dropped. The next sample 0x0400 yields 32 with out_primed=0. Then 4 more zeros give 64, 128, 256, 512, with primed set on the last.
6. Async rst asserted between clock edges during streaming -> out_valid, out_data and out_primed go to 0 immediately. Repeat scenarios 1–5 with FIR_PIPE_EN defined and expect latency 2.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and helpers for the shift-coefficient FIR.
//   SHIFT_W     - bits per packed shift amount
//   TAP_MAX     - largest supported tap count
//   shift_t     - one shift amount
//   shift_set_t - a full shift set, zero-extended to TAP_MAX entries
//   term_t      - one DATA_W-wide term for the default 16-bit build
//   shift_of()  - returns the shift amount used by tap idx
// The FIR top declares its own term array from term_t's pattern, because
// DATA_W and TAPS are module parameters that a package cannot see.
package fir_pkg;

  localparam int SHIFT_W = 4;
  localparam int TAP_MAX = 16;

  typedef logic [SHIFT_W-1:0]         shift_t;
  typedef logic [SHIFT_W*TAP_MAX-1:0] shift_set_t;
  typedef logic [15:0]                term_t;

  function automatic shift_t shift_of(input shift_set_t shifts, input int idx);
    return shifts[SHIFT_W*idx +: SHIFT_W];
  endfunction

endpackage

// File: rtl/fir_shift_approx_pipe_approx_adder.sv
// approx_adder: DATA_W-bit adder with an optional carry cut at bit APPROX_K-1.
//   a, b      - addends
//   approx_en - 1 = the carry out of bit APPROX_K-1 is a[K-1] & b[K-1] only
//   sum       - (a + b) mod 2^DATA_W, or the carry-cut variant
// Bits below APPROX_K are always added exactly among themselves; only the
// carry they would pass upward is replaced. APPROX_K = 0 gives an exact adder.
// Supported range: 0 <= APPROX_K < DATA_W.
module approx_adder #(
  parameter int DATA_W   = 16,
  parameter int APPROX_K = 2
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              approx_en,
  output logic [DATA_W-1:0] sum
);

  generate
    if (APPROX_K == 0) begin : g_exact
      logic unused_approx_en;
      assign unused_approx_en = approx_en;
      assign sum = a + b;
    end else begin : g_cut
      logic [APPROX_K:0]        low;
      logic                     carry;
      logic [DATA_W-APPROX_K-1:0] high;

      assign low   = {1'b0, a[APPROX_K-1:0]} + {1'b0, b[APPROX_K-1:0]};
      // Cut mode drops the propagate term: only a generate at bit K-1 carries.
      assign carry = approx_en ? (a[APPROX_K-1] & b[APPROX_K-1]) : low[APPROX_K];
      assign high  = a[DATA_W-1:APPROX_K] + b[DATA_W-1:APPROX_K]
                   + (DATA_W-APPROX_K)'(carry);
      assign sum   = {high, low[APPROX_K-1:0]};
    end
  endgenerate

endmodule

// File: rtl/fir_shift_approx_pipe.sv
// fir_shift_approx_pipe: multiplierless FIR, y[n] = sum_i (x[n-i] >> SHIFT_i).
//   clk, rst    - clock, asynchronous active-high reset
//   flush       - synchronous clear of history, fill count and valids
//   in_valid    - sample strobe; in_data is the newest sample (tap 0)
//   approx_en   - selects carry-cut adders for the sample taken with in_valid
//   out_valid   - result strobe; out_data holds between strobes
//   out_data    - sum modulo 2^DATA_W
//   out_primed  - result covers TAPS real samples
// Build option: define FIR_PIPE_EN for a two-stage version (terms registered,
// then the adder-chain sum), latency 2; otherwise latency 1.
import fir_pkg::*;

module fir_shift_approx_pipe #(
  parameter int                       DATA_W   = 16,
  parameter int                       TAPS     = 5,
  parameter logic [SHIFT_W*TAPS-1:0]  SHIFTS   = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5},
  parameter int                       APPROX_K = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              approx_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_primed
);

  localparam int         CNT_W      = $clog2(TAPS + 1);
  localparam shift_set_t SHIFTS_EXT = shift_set_t'(SHIFTS);

  typedef logic [DATA_W-1:0] term_arr_t [TAPS];

  logic [DATA_W-1:0] hist [TAPS-1];
  term_arr_t         tap, term, add_in, acc;
  logic              add_en;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              primed_next, accept;

  assign accept      = in_valid & ~flush;
  assign cnt_next    = (cnt == CNT_W'(TAPS)) ? cnt : cnt + 1'b1;
  assign primed_next = (cnt_next == CNT_W'(TAPS));

  always_comb begin
    tap[0] = in_data;
    for (int i = 1; i < TAPS; i++) tap[i] = hist[i-1];
    for (int i = 0; i < TAPS; i++) term[i] = tap[i] >> shift_of(SHIFTS_EXT, i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS-1; i++) hist[i] <= '0;
      cnt <= '0;
    end else if (flush) begin
      for (int i = 0; i < TAPS-1; i++) hist[i] <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      hist[0] <= in_data;
      for (int i = 1; i < TAPS-1; i++) hist[i] <= hist[i-1];
      cnt <= cnt_next;
    end
  end

  // Left-to-right chain: acc[i] = acc[i-1] + add_in[i].
  assign acc[0] = add_in[0];
  generate
    for (genvar g = 1; g < TAPS; g++) begin : g_chain
      approx_adder #(.DATA_W(DATA_W), .APPROX_K(APPROX_K)) u_add (
        .a         (acc[g-1]),
        .b         (add_in[g]),
        .approx_en (add_en),
        .sum       (acc[g])
      );
    end
  endgenerate

`ifdef FIR_PIPE_EN
  term_arr_t s1_term;
  logic      s1_approx, s1_valid, s1_primed;

  assign add_in = s1_term;
  assign add_en = s1_approx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) s1_term[i] <= '0;
      s1_approx  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_primed  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_primed <= 1'b0;
    end else begin
      s1_valid  <= accept;
      out_valid <= s1_valid & ~flush;
      if (accept) begin
        s1_term   <= term;
        s1_approx <= approx_en;
        s1_primed <= primed_next;
      end
      // flush kills the stage-1 result that would otherwise land this edge.
      if (flush) begin
        out_primed <= 1'b0;
      end else if (s1_valid) begin
        out_data   <= acc[TAPS-1];
        out_primed <= s1_primed;
      end
    end
  end
`else
  assign add_in = term;
  assign add_en = approx_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_primed <= 1'b0;
    end else begin
      out_valid <= accept;
      if (flush) begin
        out_primed <= 1'b0;
      end else if (in_valid) begin
        out_data   <= acc[TAPS-1];
        out_primed <= primed_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fir_shift_approx_pipe.sv
module tb_fir_shift_approx_pipe;

`ifdef FIR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int TAPS = 5;
  localparam int K    = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, approx_en;
  logic [15:0] in_data;
  logic        out_valid, out_primed;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  fir_shift_approx_pipe #(
    .DATA_W(16), .TAPS(TAPS), .SHIFTS({4'd1, 4'd2, 4'd3, 4'd4, 4'd5}), .APPROX_K(K)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .approx_en(approx_en), .out_valid(out_valid), .out_data(out_data),
    .out_primed(out_primed)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned shv [TAPS] = '{5, 4, 3, 2, 1};
  int unsigned hist_m [TAPS-1];
  int          m_cnt;
  bit          p_valid, p_primed;
  int unsigned p_data;
  bit          exp_valid, exp_primed;
  int unsigned exp_data;

  function automatic int unsigned aadd(input int unsigned a, input int unsigned b, input bit ap);
    int unsigned m, lo, c, hi;
    if (!ap || K == 0) return (a + b) % 65536;
    m  = 1 << K;
    lo = ((a % m) + (b % m)) % m;
    c  = (a >> (K-1)) & (b >> (K-1)) & 1;
    hi = ((a >> K) + (b >> K) + c) << K;
    return (hi + lo) % 65536;
  endfunction

  function automatic int unsigned model_sum(input int unsigned x, input bit ap);
    int unsigned s;
    s = x >> shv[0];
    for (int i = 1; i < TAPS; i++) s = aadd(s, hist_m[i-1] >> shv[i], ap);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    int unsigned r;
    bit np;
    if (rst) begin
      for (int i = 0; i < TAPS-1; i++) hist_m[i] = 0;
      m_cnt = 0; p_valid = 0; p_primed = 0; p_data = 0;
      exp_valid = 0; exp_primed = 0; exp_data = 0;
    end else begin
      r  = model_sum(32'(in_data), approx_en);
      np = (m_cnt + 1 >= TAPS);
      if (flush) begin
        exp_valid = 0; exp_primed = 0; p_valid = 0; m_cnt = 0;
        for (int i = 0; i < TAPS-1; i++) hist_m[i] = 0;
      end else begin
        if (LAT == 2) begin
          exp_valid = p_valid;
          if (p_valid) begin exp_data = p_data; exp_primed = p_primed; end
          p_valid = in_valid; p_data = r; p_primed = np;
        end else begin
          exp_valid = in_valid;
          if (in_valid) begin exp_data = r; exp_primed = np; end
        end
        if (in_valid) begin
          for (int i = TAPS-2; i > 0; i--) hist_m[i] = hist_m[i-1];
          hist_m[0] = 32'(in_data);
          if (m_cnt < TAPS) m_cnt++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out_data", 32'(out_data), exp_data);
      chk("out_primed", 32'(out_primed), 32'(exp_primed));
    end
  end

  // ---------------- capture for literal checks ----------------
  logic [15:0] got_d [$];
  bit          got_p [$];

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      got_d.push_back(out_data);
      got_p.push_back(out_primed);
    end
  end

  task automatic check_seq(input string name, input logic [15:0] ed [5], input bit ep [5]);
    chk({name, "_count"}, got_d.size(), 5);
    for (int i = 0; i < 5 && i < got_d.size(); i++) begin
      chk($sformatf("%s_data%0d", name, i), 32'(got_d[i]), 32'(ed[i]));
      chk($sformatf("%s_primed%0d", name, i), 32'(got_p[i]), 32'(ep[i]));
    end
  endtask

  task automatic drv(input bit v, input logic [15:0] d, input bit ap, input bit fl);
    @(negedge clk);
    in_valid = v; in_data = d; approx_en = ap; flush = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0; in_data = 16'h0; flush = 0;
    end
  endtask

  task automatic do_flush();
    drv(0, 16'h0, 0, 1);
    idle(2);
    got_d.delete(); got_p.delete();
  endtask

  logic [15:0] imp_d [5] = '{16'd32, 16'd64, 16'd128, 16'd256, 16'd512};
  bit          imp_p [5] = '{0, 0, 0, 0, 1};

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_data = 0; approx_en = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    #1;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_data", 32'(out_data), 0);
    chk("reset_primed", 32'(out_primed), 0);

    // impulse, exact
    do_flush();
    drv(1, 16'h0400, 0, 0);
    repeat (4) drv(1, 16'h0000, 0, 0);
    idle(4);
    check_seq("impulse", imp_d, imp_p);

    // step, exact
    do_flush();
    repeat (5) drv(1, 16'hFFFF, 0, 0);
    idle(4);
    chk("step_count", got_d.size(), 5);
    if (got_d.size() == 5) begin
      chk("step_first", 32'(got_d[0]), 2047);
      chk("step_last", 32'(got_d[4]), 63483);
      chk("step_primed4", 32'(got_p[4]), 1);
      chk("step_primed3", 32'(got_p[3]), 0);
    end

    // carry cut: exact then approximate
    do_flush();
    drv(1, 16'h0010, 0, 0);
    drv(1, 16'h0060, 0, 0);
    idle(4);
    chk("cut_exact_count", got_d.size(), 2);
    if (got_d.size() == 2) chk("cut_exact", 32'(got_d[1]), 4);
    do_flush();
    drv(1, 16'h0010, 1, 0);
    drv(1, 16'h0060, 1, 0);
    idle(4);
    chk("cut_approx_count", got_d.size(), 2);
    if (got_d.size() == 2) chk("cut_approx", 32'(got_d[1]), 0);
    approx_en = 0;

    // gapped impulse
    do_flush();
    drv(1, 16'h0400, 0, 0);
    idle(3);
    repeat (4) begin
      drv(1, 16'h0000, 0, 0);
      idle(3);
    end
    idle(2);
    check_seq("gapped", imp_d, imp_p);

    // flush with simultaneous in_valid mid-stream
    do_flush();
    repeat (3) drv(1, 16'hFFFF, 0, 0);
    drv(1, 16'hFFFF, 0, 1);
    idle(2);
    chk("flush_inflight", got_d.size(), (LAT == 1) ? 3 : 2);
    got_d.delete(); got_p.delete();
    drv(1, 16'h0400, 0, 0);
    repeat (4) drv(1, 16'h0000, 0, 0);
    idle(4);
    check_seq("flush_resume", imp_d, imp_p);

    // async reset between edges
    do_flush();
    drv(1, 16'h0400, 0, 0);
    drv(1, 16'h0000, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_data", 32'(out_data), (LAT == 1) ? 64 : 32);
    #1;
    rst = 1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    chk("async_rst_primed", 32'(out_primed), 0);
    idle(1);
    rst = 0;
    idle(1);
    got_d.delete(); got_p.delete();
    drv(1, 16'h0400, 0, 0);
    repeat (4) drv(1, 16'h0000, 0, 0);
    idle(4);
    check_seq("post_rst", imp_d, imp_p);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
